// File: rtl/alu32_reg.sv
// Registered 32-bit MIPS-style ALU: AND/OR/ADD/XOR/NOR/SUB/SLT with a zero flag, one-cycle latency.
// Optional unsigned lt/eq/gt compare flags are built when ALU32_CMP_EN is defined; otherwise tied to 0.
module alu32_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_code,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        lt,
  output logic        eq,
  output logic        gt
);

  // Handshake: in_valid qualifies a/b/alu_code on the rising edge; there is no
  // backpressure (no ready), so every valid input yields out_valid one cycle later.
  // With in_valid low the result/flag registers hold and out_valid drops.

  logic [31:0] diff;
  logic        slt_bit;
  logic [31:0] next_result;

  // Subtraction as a + ~b + 1 so SUB and SLT share one adder.
  assign diff    = a + ~b + 32'd1;
  assign slt_bit = (a[31] != b[31]) ? a[31] : diff[31];

  always_comb begin
    next_result = 32'h0;
    case (alu_code)
      3'b000:  next_result = a & b;
      3'b001:  next_result = a | b;
      3'b010:  next_result = a + b;
      3'b011:  next_result = a ^ b;
      3'b100:  next_result = ~(a | b);
      3'b110:  next_result = diff;
      3'b111:  next_result = {31'b0, slt_bit};
      default: next_result = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_result <= 32'h0;
      zero       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result <= next_result;
        zero       <= (next_result == 32'h0);
      end
    end
  end

`ifdef ALU32_CMP_EN
  logic lt_q;
  logic eq_q;
  logic gt_q;

  // Unsigned compare of the raw operands, independent of the opcode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
    end else if (in_valid) begin
      lt_q <= (a < b);
      eq_q <= (a == b);
      gt_q <= (a > b);
    end
  end

  assign lt = lt_q;
  assign eq = eq_q;
  assign gt = gt_q;
`else
  assign lt = 1'b0;
  assign eq = 1'b0;
  assign gt = 1'b0;
`endif

endmodule

// File: tb/tb_alu32_reg.sv
// Directed testbench for alu32_reg: hand-computed vectors, reset behaviour and hold/latency checks.
module tb_alu32_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_code;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic        lt;
  logic        eq;
  logic        gt;

  int total = 0;
  int bad   = 0;

  alu32_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .alu_code   (alu_code),
    .out_valid  (out_valid),
    .alu_result (alu_result),
    .zero       (zero),
    .lt         (lt),
    .eq         (eq),
    .gt         (gt)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every output; compare flags are expected at 0 when the feature is not built.
  task automatic check_out(input string tag, input logic exp_valid, input logic [31:0] exp_res,
                           input logic exp_zero, input logic exp_lt, input logic exp_eq,
                           input logic exp_gt);
    logic cl, ce, cg;
`ifdef ALU32_CMP_EN
    cl = exp_lt; ce = exp_eq; cg = exp_gt;
`else
    cl = 1'b0; ce = 1'b0; cg = 1'b0;
`endif
    check({tag, ".valid"},  {31'b0, out_valid}, {31'b0, exp_valid});
    check({tag, ".result"}, alu_result, exp_res);
    check({tag, ".zero"},   {31'b0, zero}, {31'b0, exp_zero});
    check({tag, ".lt"},     {31'b0, lt}, {31'b0, cl});
    check({tag, ".eq"},     {31'b0, eq}, {31'b0, ce});
    check({tag, ".gt"},     {31'b0, gt}, {31'b0, cg});
  endtask

  // Driver: present one valid operation, then sample just after the capturing edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] code);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    alu_code = code;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [31:0] ta, input logic [31:0] tb);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ta;
    b        = tb;
    alu_code = 3'b010;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    alu_code = 3'b000;
    #1;
    check_out("reset_init", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue(32'h18000441, 32'h18642201, 3'b000);
    check_out("and", 1'b1, 32'h18000001, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'h18000441, 32'h18642201, 3'b001);
    check_out("or", 1'b1, 32'h18642641, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'h18000441, 32'h18642201, 3'b010);
    check_out("add", 1'b1, 32'h30642642, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b010);
    check_out("add_wrap", 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h0001E240, 32'h00051A09, 3'b110);
    check_out("sub_neg", 1'b1, 32'hFFFCC837, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'h00051A09, 32'h0001E240, 3'b110);
    check_out("sub_pos", 1'b1, 32'h000337C9, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h12345678, 32'h12345678, 3'b110);
    check_out("sub_eq", 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(32'h38000441, 32'h18642201, 3'b011);
    check_out("xor", 1'b1, 32'h20642640, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h00000000, 32'h00000000, 3'b100);
    check_out("nor", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(32'h80000000, 32'h00000001, 3'b111);
    check_out("slt_signdiff", 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'h00000001, 32'h80000000, 3'b111);
    check_out("slt_signdiff_rev", 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(32'h00000005, 32'h00000007, 3'b111);
    check_out("slt_pos", 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFE, 3'b111);
    check_out("slt_neg", 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'h000000FF, 32'h000000FF, 3'b101);
    check_out("reserved", 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Hold: in_valid low keeps result/flags and drops out_valid.
    issue(32'h00000010, 32'h00000003, 3'b010);
    check_out("pre_hold", 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle(32'h00000001, 32'h00000009);
    check_out("hold", 1'b0, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges, then held while reset stays high.
    #3;
    reset = 1'b1;
    #1;
    check_out("reset_async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h00000001, 32'h00000002, 3'b010);
    check_out("reset_held", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("release_op", 1'b1, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle(32'h00000000, 32'h00000000);
    check_out("release_hold", 1'b0, 32'h00000003, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset coincident with a capturing edge discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h00000007;
    b        = 32'h00000008;
    alu_code = 3'b010;
    @(posedge clk);
    reset = 1'b1;
    #1;
    check_out("reset_edge", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    check_out("after_edge_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
